// File: rtl/friscv_muldiv_if.sv
// rtl/friscv_muldiv_if.sv - request/result handshake bundle for the iterative mul/div unit
interface friscv_muldiv_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output flush_i, valid_i, op_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, op_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, busy_o
    );
endinterface

// File: rtl/friscv_muldiv.sv
// rtl/friscv_muldiv.sv - radix-2 iterative RV32M multiply/divide unit
module friscv_muldiv #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = $clog2(XLEN) + 1
) (
    input  logic clk,
    input  logic rst,
    friscv_muldiv_if.slave io
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic [2:0]            op;
    logic                  negate;
    logic                  special;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [XLEN-1:0]       opa;
    logic [XLEN-1:0]       opb;
    logic [XLEN-1:0]       rem;
    logic [XLEN-1:0]       result;
    logic [2*XLEN-1:0]     prod;

    logic                  a_signed;
    logic                  b_signed;
    logic                  a_neg;
    logic                  b_neg;
    logic [XLEN-1:0]       mag_a;
    logic [XLEN-1:0]       mag_b;
    logic                  b_zero;
    logic                  overflow;
    logic                  special_in;
    logic                  negate_in;
    logic [XLEN-1:0]       special_res;

    logic [XLEN:0]         rem_shift;
    logic [XLEN:0]         rem_diff;
    logic [2*XLEN-1:0]     prod_step;
    logic [2*XLEN-1:0]     prod_fix;
    logic [XLEN-1:0]       div_sel;
    logic [XLEN-1:0]       div_fix;

    // Request decode: magnitudes, final sign and the cases resolved without iterating
    always_comb begin
        a_signed  = (io.op_i == 3'b001) || (io.op_i == 3'b010) ||
                    (io.op_i == 3'b100) || (io.op_i == 3'b110);
        b_signed  = (io.op_i == 3'b001) || (io.op_i == 3'b100) || (io.op_i == 3'b110);
        a_neg     = a_signed && io.a_i[XLEN-1];
        b_neg     = b_signed && io.b_i[XLEN-1];
        mag_a     = a_neg ? -io.a_i : io.a_i;
        mag_b     = b_neg ? -io.b_i : io.b_i;
        b_zero    = (io.b_i == '0);
        overflow  = ((io.op_i == 3'b100) || (io.op_i == 3'b110)) &&
                    (io.a_i == MOST_NEG) && (io.b_i == '1);
        special_in = io.op_i[2] && (b_zero || overflow);
        if (b_zero) begin
            special_res = io.op_i[1] ? io.a_i : '1;
        end else begin
            special_res = io.op_i[1] ? '0 : io.a_i;
        end
        // Remainder follows the dividend; products and quotients follow the sign mismatch
        negate_in = (io.op_i[2] && io.op_i[1]) ? a_neg : (a_neg ^ b_neg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        io.ready_o  = (state == IDLE);
        io.busy_o   = (state != IDLE);
        io.valid_o  = (state == DONE);
        io.result_o = result;
        case (state)
            IDLE: begin
                if (io.valid_i) begin
                    accept     = 1'b1;
                    state_next = special_in ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_next = FIX;
                end
            end
            FIX:  state_next = DONE;
            DONE: begin
                if (io.ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (io.flush_i) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
    end

    // One shift-add (MSB-first) or one restoring-division step per BUSY cycle
    always_comb begin
        rem_shift = {rem, opa[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, opb};
        prod_step = {prod[2*XLEN-2:0], 1'b0} +
                    (opa[XLEN-1] ? {{XLEN{1'b0}}, opb} : {(2*XLEN){1'b0}});
        prod_fix  = negate ? -prod : prod;
        div_sel   = op[1] ? rem : opa;
        div_fix   = negate ? -div_sel : div_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= '0;
            negate  <= 1'b0;
            special <= 1'b0;
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            rem     <= '0;
            prod    <= '0;
            result  <= '0;
        end else if (accept) begin
            op      <= io.op_i;
            negate  <= negate_in;
            special <= special_in;
            cnt     <= CNT_WIDTH'(XLEN);
            opa     <= mag_a;
            opb     <= mag_b;
            rem     <= '0;
            prod    <= '0;
            if (special_in) begin
                result <= special_res;
            end
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_WIDTH'(1);
            if (op[2]) begin
                if (!rem_diff[XLEN]) begin
                    rem <= rem_diff[XLEN-1:0];
                    opa <= {opa[XLEN-2:0], 1'b1};
                end else begin
                    rem <= rem_shift[XLEN-1:0];
                    opa <= {opa[XLEN-2:0], 1'b0};
                end
            end else begin
                prod <= prod_step;
                opa  <= {opa[XLEN-2:0], 1'b0};
            end
        end else if ((state == FIX) && !special) begin
            if (op[2]) begin
                result <= div_fix;
            end else if (op[1:0] == 2'b00) begin
                result <= prod_fix[XLEN-1:0];
            end else begin
                result <= prod_fix[2*XLEN-1:XLEN];
            end
        end
    end
endmodule

// File: tb/tb_friscv_muldiv.sv
// tb/tb_friscv_muldiv.sv - self-checking bench for friscv_muldiv
module tb_friscv_muldiv;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    friscv_muldiv_if #(.XLEN(XLEN)) bus();

    friscv_muldiv #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ua;
        longint     ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_val(input int kind);
        case (kind)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // Present a request for one cycle; returns at the falling edge of cycle 1
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int busy_cycles);
        cyc         = 1;
        busy_cycles = bus.busy_o ? 1 : 0;
        while (bus.valid_o !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.busy_o) busy_cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        int bc;
        start_op(op, a, b);
        wait_valid(cyc, bc);
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, bus.result_o, exp);
        @(negedge clk);
    endtask

    initial begin
        int          cyc;
        int          bc;
        bit          seen;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_result", bus.result_o, 0);
        rst = 1'b0;

        start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        wait_valid(cyc, bc);
        check("mul_lat", cyc, 34);
        check("mul_res", bus.result_o, 32'hFFFF_FFEB);
        check("mul_busy_cycles", bc, 34);
        @(negedge clk);
        check("mul_idle_busy", bus.busy_o, 0);
        check("mul_idle_ready", bus.ready_o, 1);

        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        34);
        run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         34);
        run_op("div0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",  3'd7, 32'd5,         32'd0,         32'd5,         1);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // flush wins over a simultaneous request
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.a_i     = 32'd9;
        bus.b_i     = 32'd3;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_accept_busy", bus.busy_o, 0);
        check("flush_accept_ready", bus.ready_o, 1);

        // backpressure, then consume with a request waiting
        bus.ready_i = 1'b0;
        start_op(3'd5, 32'd100, 32'd7);
        wait_valid(cyc, bc);
        check("bp_lat", cyc, 34);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_res", bus.result_o, 32'd14);
            check("bp_hold_valid", bus.valid_o, 1);
            check("bp_hold_ready", bus.ready_o, 0);
        end
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd4;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd7;
        @(negedge clk);
        check("b2b_idle_ready", bus.ready_o, 1);
        check("b2b_idle_busy", bus.busy_o, 0);
        check("b2b_idle_valid", bus.valid_o, 0);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check("b2b_accepted", bus.busy_o, 1);
        wait_valid(cyc, bc);
        check("b2b_lat", cyc, 34);
        check("b2b_res", bus.result_o, 32'd14);
        @(negedge clk);

        // flush in cycle 10 of a divide
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_busy", bus.busy_o, 0);
        check("flush_ready", bus.ready_o, 1);
        check("flush_valid", bus.valid_o, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1'b1;
        end
        check("flush_no_valid", seen, 0);

        // reset in cycle 10 of a divide
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", bus.ready_o, 1);
        check("midrst_valid", bus.valid_o, 0);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_result", bus.result_o, 0);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_val($urandom_range(0, 8));
            rb  = pick_val($urandom_range(0, 8));
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb),
                   is_special(rop, ra, rb) ? 1 : 34);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/friscv_muldiv.md
FRISCV_MULDIV -- requirements
Module: friscv_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 8..64 in powers of two.
REQ-002 The block SHALL have parameter CNT_WIDTH, default $clog2(XLEN)+1, giving the iteration counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
REQ-004 The block SHALL have these remaining ports:
- flush_i  in  1  abort any in-flight operation.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request.
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result.
- busy_o  out  1  state is not IDLE.

Function
REQ-005 The block SHALL implement the FSM states IDLE, BUSY, FIX and DONE.
REQ-006 ready_o SHALL be 1 only in IDLE, and busy_o SHALL equal (state != IDLE).
REQ-007 A request SHALL be accepted on a rising edge with valid_i && ready_o.
- On acceptance, op, operand magnitudes, result-negate flag and special-case flag SHALL be latched.
- Cycle of acceptance = cycle 0.
REQ-008 IDLE->BUSY on acceptance; the counter SHALL be loaded with XLEN.
- BUSY SHALL perform one radix-2 iteration per cycle for XLEN cycles (cycles 1..XLEN).
- BUSY->FIX when the counter reaches 1.
REQ-009 Multiply SHALL use shift-add on unsigned magnitudes into a 2*XLEN product.
- MUL: low XLEN bits of the product.
- MULH/MULHSU/MULHU: high XLEN bits of the product.
- Operand signedness: MULH signed x signed; MULHSU signed a_i x unsigned b_i; MULHU unsigned x unsigned.
REQ-010 Divide SHALL use restoring division on unsigned magnitudes, one quotient bit per cycle, MSB first.
REQ-011 FIX (cycle XLEN+1) SHALL apply two's-complement sign correction.
- Product: negated when the operand signs differ (signed ops only).
- Quotient: negated when the operand signs differ (DIV only).
- Remainder: takes the sign of the dividend (REM only).
- FIX->DONE unconditionally.
REQ-012 DONE SHALL drive valid_o=1, first in cycle XLEN+2 after acceptance.
- result_o SHALL be registered and held stable while valid_o=1 && !ready_i.
- DONE->IDLE on valid_o && ready_i.
REQ-013 Special cases SHALL skip BUSY/FIX, going IDLE->DONE with valid_o=1 in cycle 1:
- b_i==0: DIV/DIVU -> all ones; REM/REMU -> a_i.
- DIV with a_i==most-negative and b_i==all ones: result = a_i.
- REM with a_i==most-negative and b_i==all ones: result = 0.
REQ-014 A new request SHALL NOT be accepted in the same cycle a result is consumed; ready_o rises in the cycle after the DONE->IDLE transition.
REQ-015 flush_i=1 SHALL force the state to IDLE on the next edge from any state.
- The aborted result SHALL be discarded; valid_o SHALL be 0 in the following cycle.
- flush_i SHALL override acceptance: valid_i && ready_o && flush_i accepts nothing.
REQ-016 valid_o SHALL be 0 in every state other than DONE.
- result_o SHALL be don't-care when valid_o=0, but SHALL NOT carry X after reset.
REQ-017 Internal arithmetic SHALL use XLEN+1 bits for the remainder and 2*XLEN bits for the product; no other widths are permitted.

Reset
REQ-018 rst=1 at an edge SHALL set state=IDLE, counter=0, and all datapath registers to 0.
- Resulting outputs: ready_o=1, valid_o=0, busy_o=0, result_o=0.
REQ-019 rst SHALL take priority over flush_i, valid_i and ready_i, including in the middle of an operation.

Verification
REQ-020 The bench SHALL cover these directed scenarios (XLEN=32):
- MUL a=7, b=0xFFFFFFFD, ready_i=1 -> valid_o in cycle 34, result_o=0xFFFFFFEB, busy_o high cycles 1..34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF in cycle 1; REMU 5/0 -> 5 in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM same operands -> 0.
- Backpressure: ready_i=0 for 5 cycles after valid_o -> result_o stable, ready_o=0; ready_i=1 -> IDLE next edge, ready_o=1, a back-to-back request is accepted.
- flush_i pulse in cycle 10 of a DIV -> IDLE in cycle 11, valid_o never asserted; repeat with rst instead of flush_i -> reset values per REQ-018.
